// File: rtl/knn_vote.sv
// k-nearest-neighbour majority vote over a sorted bucket chain.
// Scans buckets from nearest outward, tallies classes, then picks the winner.
module knn_vote #(
   parameter int N  = 35,
   parameter int K  = 8,
   parameter int IW = 3,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [IW-1:0] rd_idx,
   input  logic          rd_full,
   input  logic [N-1:0]  rd_data,
   output logic          busy,
   output logic          done,
   output logic [2:0]    class_out,
   output logic [CW-1:0] votes,
   output logic          no_data
);

   typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;

   localparam logic [IW-1:0] LAST   = IW'(K - 1);
   localparam logic [IW:0]   NO_IDX = (IW + 1)'(K);

   state_t state, state_nx;

   logic [CW-1:0] cnt   [8];
   logic [IW-1:0] first [8];
   logic [2:0]    dc;
   logic [2:0]    best_class;
   logic [CW-1:0] best_cnt;
   logic [IW:0]   best_first;

   logic [2:0]    rd_class;
   logic          scan_end;
   logic          upd;
   logic [2:0]    nb_class;
   logic [CW-1:0] nb_cnt;
   logic [IW:0]   nb_first;
   logic          dist_unused;

   assign rd_class    = rd_data[N-1:N-3];
   assign dist_unused = ^rd_data[N-4:0];
   assign scan_end    = !rd_full || (rd_idx == LAST);

   // Equal counts fall back to the class whose earliest entry is nearest.
   always_comb begin
      upd      = 1'b0;
      nb_class = best_class;
      nb_cnt   = best_cnt;
      nb_first = best_first;
      if (cnt[dc] > best_cnt ||
          (cnt[dc] == best_cnt && cnt[dc] != '0 && {1'b0, first[dc]} < best_first))
         upd = 1'b1;
      if (upd) begin
         nb_class = dc;
         nb_cnt   = cnt[dc];
         nb_first = {1'b0, first[dc]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SCAN;
         SCAN:    if (scan_end) state_nx = DECIDE;
         DECIDE:  if (dc == 3'd7) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_idx     <= '0;
         dc         <= '0;
         best_class <= '0;
         best_cnt   <= '0;
         best_first <= NO_IDX;
         class_out  <= '0;
         votes      <= '0;
         no_data    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            cnt[i]   <= '0;
            first[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (start) begin
               rd_idx     <= '0;
               dc         <= '0;
               best_class <= '0;
               best_cnt   <= '0;
               best_first <= NO_IDX;
               for (int i = 0; i < 8; i++) begin
                  cnt[i]   <= '0;
                  first[i] <= '0;
               end
            end
            SCAN: begin
               if (rd_full) begin
                  cnt[rd_class] <= cnt[rd_class] + 1'b1;
                  if (cnt[rd_class] == '0) first[rd_class] <= rd_idx;
               end
               if (scan_end) rd_idx <= '0;
               else          rd_idx <= rd_idx + 1'b1;
            end
            DECIDE: begin
               best_class <= nb_class;
               best_cnt   <= nb_cnt;
               best_first <= nb_first;
               dc         <= dc + 3'd1;
               // Publish on the last compare so results are stable during DONE.
               if (dc == 3'd7) begin
                  class_out <= nb_class;
                  votes     <= nb_cnt;
                  no_data   <= (nb_cnt == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == SCAN) || (state == DECIDE);
   assign done = (state == DONE);

endmodule
